// File: rtl/updi_target_responder.sv
// rtl/updi_target_responder.sv - UPDI target responder serving SYNCH/LDCS/STCS/LDS/STS/KEY over UART FIFOs
module updi_target_responder #(
    parameter int          MEM_SIZE         = 256,
    parameter int          MEM_ADDR_BITS    = $clog2(MEM_SIZE),
    parameter logic [63:0] KEY_CHIPERASE    = 64'h4E564D4572617365,
    parameter bit          LOCKED_AT_RESET  = 1'b1,
    parameter logic [7:0]  STATUSA_VALUE    = 8'h30,
    parameter int          ERASE_EXTRA_CLKS = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] uart_rx_fifo_data_out,
    output logic       uart_rx_fifo_rd_en,
    input  logic       uart_rx_fifo_empty,
    output logic [7:0] uart_tx_fifo_data_in,
    output logic       uart_tx_fifo_wr_en,
    input  logic       uart_tx_fifo_full,
    input  logic       double_break_detected,
    output logic       locked,
    output logic       erase_busy,
    output logic       protocol_error
);
    localparam int ECNT_BITS = $clog2(MEM_SIZE + ERASE_EXTRA_CLKS + 1);
    localparam logic [ECNT_BITS-1:0] FILL_END  = ECNT_BITS'(MEM_SIZE);
    localparam logic [ECNT_BITS-1:0] ERASE_END = ECNT_BITS'(MEM_SIZE + ERASE_EXTRA_CLKS - 1);
    localparam logic [7:0] SYNCH = 8'h55;
    localparam logic [7:0] ACK   = 8'h40;

    typedef enum logic [3:0] {
        S_WAIT_SYNC, S_OPCODE, S_ADDR, S_LDCS, S_STCS,
        S_LDS, S_STS_ACK, S_STS_DATA, S_KEY, S_ERROR
    } state_t;

    state_t                   state;
    logic                     rx_sample;
    logic                     tx_valid;
    logic [7:0]               tx_data;
    logic                     is_store;
    logic [3:0]               cs_addr;
    logic [MEM_ADDR_BITS-1:0] addr;
    logic [1:0]               addr_idx;
    logic [1:0]               addr_last;
    logic [1:0]               data_left;
    logic [2:0]               key_idx;
    logic                     key_match;
    logic [7:0]               cs7;
    logic [7:0]               cs8;
    logic                     rstsys;
    logic [ECNT_BITS-1:0]     erase_cnt;
    logic [7:0]               mem [MEM_SIZE];

    logic [7:0]               rx_byte;
    logic [7:0]               cs_rdata;
    logic [7:0]               mem_rdata;
    logic                     rx_state;
    logic                     tx_push;
    logic                     key_byte_ok;
    logic                     mem_we;
    logic [MEM_ADDR_BITS-1:0] mem_waddr;
    logic [7:0]               mem_wdata;

    assign rx_byte              = uart_rx_fifo_data_out;
    assign tx_push              = tx_valid && !uart_tx_fifo_full && state != S_ERROR;
    assign uart_tx_fifo_wr_en   = tx_push;
    assign uart_tx_fifo_data_in = tx_data;
    assign mem_rdata            = mem[addr];
    assign key_byte_ok          = rx_byte == KEY_CHIPERASE[{key_idx, 3'b000} +: 8];

    always_comb begin
        rx_state = 1'b0;
        case (state)
            S_WAIT_SYNC, S_OPCODE, S_ADDR, S_STCS, S_STS_DATA, S_KEY: rx_state = 1'b1;
            default: rx_state = 1'b0;
        endcase
    end

    always_comb begin
        cs_rdata = 8'h00;
        case (cs_addr)
            4'h0:    cs_rdata = STATUSA_VALUE;
            4'h7:    cs_rdata = cs7;
            4'h8:    cs_rdata = cs8;
            4'hB:    cs_rdata = {2'b00, rstsys, 4'b0000, locked};
            default: cs_rdata = 8'h00;
        endcase
    end

    // The erase fill owns the single write port; STS data is dropped while locked or erasing.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = rx_byte;
        if (erase_busy && erase_cnt < FILL_END) begin
            mem_we    = 1'b1;
            mem_waddr = erase_cnt[MEM_ADDR_BITS-1:0];
            mem_wdata = 8'hFF;
        end else if (state == S_STS_DATA && rx_sample && !rst && !double_break_detected
                     && !locked && !erase_busy) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= S_WAIT_SYNC;
            uart_rx_fifo_rd_en <= 1'b0;
            rx_sample          <= 1'b0;
            tx_valid           <= 1'b0;
            tx_data            <= 8'h00;
            is_store           <= 1'b0;
            cs_addr            <= 4'h0;
            addr               <= '0;
            addr_idx           <= 2'd0;
            addr_last          <= 2'd0;
            data_left          <= 2'd0;
            key_idx            <= 3'd0;
            key_match          <= 1'b0;
            cs7                <= 8'h00;
            cs8                <= 8'h00;
            rstsys             <= 1'b0;
            locked             <= LOCKED_AT_RESET;
            erase_busy         <= 1'b0;
            erase_cnt          <= '0;
            protocol_error     <= 1'b0;
        end else begin
            uart_rx_fifo_rd_en <= 1'b0;
            rx_sample          <= uart_rx_fifo_rd_en;
            if (tx_push) tx_valid <= 1'b0;

            if (erase_busy) begin
                if (erase_cnt == ERASE_END) begin
                    erase_busy <= 1'b0;
                    locked     <= 1'b0;
                    cs7[3]     <= 1'b0;
                end else begin
                    erase_cnt <= erase_cnt + ECNT_BITS'(1);
                end
            end

            if (double_break_detected) begin
                state          <= S_WAIT_SYNC;
                protocol_error <= 1'b0;
                rx_sample      <= 1'b0;
                tx_valid       <= 1'b0;
            end else begin
                if (rx_state && !uart_rx_fifo_rd_en && !rx_sample && !uart_rx_fifo_empty)
                    uart_rx_fifo_rd_en <= 1'b1;

                case (state)
                    S_WAIT_SYNC: if (rx_sample) begin
                        if (rx_byte == SYNCH) begin
                            state <= S_OPCODE;
                        end else begin
                            protocol_error <= 1'b1;
                            state          <= S_ERROR;
                        end
                    end
                    S_OPCODE: if (rx_sample) begin
                        case (rx_byte[7:5])
                            3'b000, 3'b010: begin
                                if (rx_byte[3:2] == 2'd3 || rx_byte[1]) begin
                                    protocol_error <= 1'b1;
                                    state          <= S_ERROR;
                                end else begin
                                    is_store  <= rx_byte[6];
                                    addr      <= '0;
                                    addr_idx  <= 2'd0;
                                    addr_last <= rx_byte[3:2];
                                    data_left <= rx_byte[0] ? 2'd2 : 2'd1;
                                    state     <= S_ADDR;
                                end
                            end
                            3'b100: begin
                                cs_addr <= rx_byte[3:0];
                                state   <= S_LDCS;
                            end
                            3'b110: begin
                                cs_addr <= rx_byte[3:0];
                                state   <= S_STCS;
                            end
                            3'b111: begin
                                if (!rx_byte[4] && !rx_byte[2] && rx_byte[1:0] == 2'd0) begin
                                    key_idx   <= 3'd0;
                                    key_match <= 1'b1;
                                    state     <= S_KEY;
                                end else begin
                                    protocol_error <= 1'b1;
                                    state          <= S_ERROR;
                                end
                            end
                            default: begin
                                protocol_error <= 1'b1;
                                state          <= S_ERROR;
                            end
                        endcase
                    end
                    S_ADDR: if (rx_sample) begin
                        // Bytes above the memory index width only matter modulo MEM_SIZE.
                        addr     <= addr | MEM_ADDR_BITS'({16'h0000, rx_byte} << {addr_idx, 3'b000});
                        addr_idx <= addr_idx + 2'd1;
                        if (addr_idx == addr_last) state <= is_store ? S_STS_ACK : S_LDS;
                    end
                    S_LDCS: if (!tx_valid) begin
                        tx_data  <= cs_rdata;
                        tx_valid <= 1'b1;
                        state    <= S_WAIT_SYNC;
                    end
                    S_STCS: if (rx_sample) begin
                        case (cs_addr)
                            4'h7: cs7 <= rx_byte;
                            4'h8: begin
                                cs8 <= rx_byte;
                                if (rx_byte == 8'h59) begin
                                    rstsys <= 1'b1;
                                end else if (rstsys) begin
                                    rstsys <= 1'b0;
                                    if (cs7[3] && !erase_busy) begin
                                        erase_busy <= 1'b1;
                                        erase_cnt  <= '0;
                                    end
                                end
                            end
                            default: ;
                        endcase
                        state <= S_WAIT_SYNC;
                    end
                    S_LDS: if (!tx_valid) begin
                        tx_data   <= (locked || erase_busy) ? 8'h00 : mem_rdata;
                        tx_valid  <= 1'b1;
                        addr      <= addr + MEM_ADDR_BITS'(1);
                        data_left <= data_left - 2'd1;
                        if (data_left == 2'd1) state <= S_WAIT_SYNC;
                    end
                    S_STS_ACK: if (!tx_valid) begin
                        tx_data  <= ACK;
                        tx_valid <= 1'b1;
                        state    <= (data_left == 2'd0) ? S_WAIT_SYNC : S_STS_DATA;
                    end
                    S_STS_DATA: if (rx_sample) begin
                        addr      <= addr + MEM_ADDR_BITS'(1);
                        data_left <= data_left - 2'd1;
                        state     <= S_STS_ACK;
                    end
                    S_KEY: if (rx_sample) begin
                        if (!key_byte_ok) key_match <= 1'b0;
                        key_idx <= key_idx + 3'd1;
                        if (key_idx == 3'd7) begin
                            if (key_match && key_byte_ok) cs7[3] <= 1'b1;
                            state <= S_WAIT_SYNC;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_updi_target_responder.sv
// tb/tb_updi_target_responder.sv - directed and randomized bench for updi_target_responder
module tb_updi_target_responder;
    localparam int          MEM_SIZE    = 256;
    localparam int          ERASE_EXTRA = 50;
    localparam logic [63:0] KEY         = 64'h4E564D4572617365;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] uart_rx_fifo_data_out = 8'h00;
    logic       uart_rx_fifo_rd_en;
    logic       uart_rx_fifo_empty;
    logic [7:0] uart_tx_fifo_data_in;
    logic       uart_tx_fifo_wr_en;
    logic       uart_tx_fifo_full = 1'b0;
    logic       double_break_detected = 1'b0;
    logic       locked;
    logic       erase_busy;
    logic       protocol_error;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] rx_mem [4096];
    int         rx_wr = 0;
    int         rx_rd = 0;
    logic [7:0] tx_mem [4096];
    int         tx_wr = 0;
    int         tx_rd = 0;
    int         push_full = 0;
    int         pop_empty = 0;

    logic [7:0]  ref_mem [MEM_SIZE];
    bit          m_locked = 1'b1;
    bit          m_key = 1'b0;
    bit          m_rstsys = 1'b0;
    logic [63:0] key_v;
    logic [7:0]  b;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [15:0] a;
    int          bad_i;
    int          kind;
    int          cnt;

    updi_target_responder dut (
        .clk                   (clk),
        .rst                   (rst),
        .uart_rx_fifo_data_out (uart_rx_fifo_data_out),
        .uart_rx_fifo_rd_en    (uart_rx_fifo_rd_en),
        .uart_rx_fifo_empty    (uart_rx_fifo_empty),
        .uart_tx_fifo_data_in  (uart_tx_fifo_data_in),
        .uart_tx_fifo_wr_en    (uart_tx_fifo_wr_en),
        .uart_tx_fifo_full     (uart_tx_fifo_full),
        .double_break_detected (double_break_detected),
        .locked                (locked),
        .erase_busy            (erase_busy),
        .protocol_error        (protocol_error)
    );

    always #5 clk = ~clk;

    assign uart_rx_fifo_empty = (rx_rd == rx_wr);

    always @(posedge clk) begin
        if (uart_rx_fifo_rd_en) begin
            if (rx_rd != rx_wr) begin
                uart_rx_fifo_data_out <= rx_mem[rx_rd];
                rx_rd <= rx_rd + 1;
            end else begin
                pop_empty <= pop_empty + 1;
            end
        end
        if (uart_tx_fifo_wr_en) begin
            tx_mem[tx_wr] <= uart_tx_fifo_data_in;
            tx_wr <= tx_wr + 1;
            if (uart_tx_fifo_full) push_full <= push_full + 1;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] v);
        rx_mem[rx_wr] = v;
        rx_wr++;
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        int t;
        int obs;
        t = 0;
        while (tx_wr == tx_rd && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (tx_wr == tx_rd) begin
            obs = -1;
        end else begin
            obs = int'(tx_mem[tx_rd]);
            tx_rd++;
        end
        check(tag, obs, int'(exp));
    endtask

    task automatic expect_quiet(input string tag);
        repeat (30) @(negedge clk);
        check(tag, tx_wr - tx_rd, 0);
    endtask

    task automatic ldcs(input logic [3:0] csa, input logic [7:0] exp, input string tag);
        put(8'h55);
        put({4'h8, csa});
        expect_byte(tag, exp);
    endtask

    task automatic pulse_break();
        @(negedge clk);
        double_break_detected = 1'b1;
        @(negedge clk);
        double_break_detected = 1'b0;
    endtask

    function automatic logic [7:0] m_csb();
        return {2'b00, m_rstsys, 4'b0000, m_locked};
    endfunction

    function automatic logic [7:0] m_cs7();
        return m_key ? 8'h08 : 8'h00;
    endfunction

    initial begin
        key_v = KEY;
        repeat (3) @(negedge clk);
        check("rst_locked", locked, 1);
        check("rst_erase_busy", erase_busy, 0);
        check("rst_protocol_error", protocol_error, 0);
        check("rst_rd_en", uart_rx_fifo_rd_en, 0);
        check("rst_wr_en", uart_tx_fifo_wr_en, 0);
        rst = 1'b0;
        @(negedge clk);

        ldcs(4'h0, 8'h30, "ldcs_statusa");
        expect_quiet("ldcs_single_byte");
        ldcs(4'hB, m_csb(), "ldcs_sys_status_locked");

        bad_i = $urandom_range(0, 7);
        put(8'h55);
        put(8'hE0);
        for (int i = 0; i < 8; i++) begin
            b = key_v[8*i +: 8];
            if (i == bad_i) b = b ^ 8'($urandom_range(1, 255));
            put(b);
        end
        ldcs(4'h7, m_cs7(), "wrong_key_status");

        put(8'h55);
        put(8'hE0);
        for (int i = 0; i < 8; i++) put(key_v[8*i +: 8]);
        m_key = 1'b1;
        ldcs(4'h7, m_cs7(), "good_key_status");

        put(8'h55);
        put(8'hC8);
        put(8'h59);
        m_rstsys = 1'b1;
        ldcs(4'hB, m_csb(), "rstsys_set");

        put(8'h55);
        put(8'hC8);
        put(8'h00);
        m_rstsys = 1'b0;
        cnt = 0;
        while (!erase_busy && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("erase_started", erase_busy, 1);
        cnt = 0;
        while (erase_busy && cnt < 2000) begin
            cnt++;
            if (cnt == 20) begin
                put(8'h55);
                put(8'h00);
                put(8'h12);
            end
            @(negedge clk);
        end
        check("erase_duration", cnt, MEM_SIZE + ERASE_EXTRA);
        expect_byte("lds_during_erase", 8'h00);
        for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = 8'hFF;
        m_locked = 1'b0;
        m_key = 1'b0;
        check("unlocked_after_erase", locked, int'(m_locked));

        ldcs(4'hB, m_csb(), "sys_status_after_erase");
        ldcs(4'h7, m_cs7(), "key_status_after_erase");
        put(8'h55);
        put(8'h00);
        put(8'h12);
        expect_byte("lds_erased", ref_mem[8'h12]);

        put(8'h55);
        put(8'h44);
        put(8'h34);
        put(8'h12);
        expect_byte("sts_addr_ack", 8'h40);
        put(8'hA5);
        expect_byte("sts_data_ack", 8'h40);
        ref_mem[8'h34] = 8'hA5;
        put(8'h55);
        put(8'h04);
        put(8'h34);
        put(8'h12);
        expect_byte("lds_wrapped", ref_mem[8'h34]);

        uart_tx_fifo_full = 1'b1;
        put(8'h55);
        put(8'h05);
        put(8'h34);
        put(8'h00);
        repeat (40) @(negedge clk);
        check("held_while_full", tx_wr - tx_rd, 0);
        uart_tx_fifo_full = 1'b0;
        expect_byte("word_low_after_full", ref_mem[8'h34]);
        expect_byte("word_high_after_full", ref_mem[8'h35]);
        check("no_push_while_full", push_full, 0);

        for (int it = 0; it < 24; it++) begin
            kind = $urandom_range(0, 4);
            a  = 16'($urandom);
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            case (kind)
                0, 1: begin
                    put(8'h55);
                    put(kind == 1 ? 8'h45 : 8'h44);
                    put(a[7:0]);
                    put(a[15:8]);
                    put(d0);
                    if (kind == 1) put(d1);
                    expect_byte("rnd_sts_addr_ack", 8'h40);
                    expect_byte("rnd_sts_data_ack", 8'h40);
                    if (kind == 1) expect_byte("rnd_sts_word_ack", 8'h40);
                    ref_mem[a[7:0]] = d0;
                    if (kind == 1) ref_mem[8'(a[7:0] + 8'd1)] = d1;
                end
                2, 3: begin
                    put(8'h55);
                    put(kind == 3 ? 8'h05 : 8'h04);
                    put(a[7:0]);
                    put(a[15:8]);
                    expect_byte("rnd_lds_low", ref_mem[a[7:0]]);
                    if (kind == 3) expect_byte("rnd_lds_high", ref_mem[8'(a[7:0] + 8'd1)]);
                end
                default: ldcs(4'h0, 8'h30, "rnd_ldcs_statusa");
            endcase
        end
        expect_quiet("rnd_no_extra_bytes");

        put(8'h3A);
        put(8'h55);
        put(8'h80);
        repeat (30) @(negedge clk);
        check("bad_synch_error", protocol_error, 1);
        check("error_stops_pops", rx_wr - rx_rd, 2);
        check("error_no_reply", tx_wr - tx_rd, 0);
        pulse_break();
        check("break_clears_error", protocol_error, 0);
        expect_byte("ldcs_after_break", 8'h30);

        put(8'h55);
        put(8'h0C);
        repeat (30) @(negedge clk);
        check("bad_size_error", protocol_error, 1);
        pulse_break();
        put(8'h55);
        put(8'hCB);
        put(8'h01);
        ldcs(4'hB, m_csb(), "sys_status_write_ignored");
        check("no_pop_when_empty", pop_empty, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
